// File: rtl/io_stall_ctrl_if.sv
// Bundles the io_stall_ctrl handshake signals: decoder strobes and board I/O
// coming in, and PC/register-file/display control going out.
//   master : control unit / board side, drives the strobes and I/O words
//   slave  : io_stall_ctrl, drives pc_en, the IN write-back and the display latch
interface io_stall_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              inop;
  logic              outop;
  logic              sleep;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              resume;
  logic              pc_en;
  logic              in_ack;
  logic              rd_we;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_reg;
  logic              out_valid;
  logic              halted;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output inop, outop, sleep, in_data, in_valid, out_data, resume,
    input  pc_en, in_ack, rd_we, rd_data, out_reg, out_valid, halted, stall_cycles
  );

  modport slave (
    input  inop, outop, sleep, in_data, in_valid, out_data, resume,
    output pc_en, in_ack, rd_we, rd_data, out_reg, out_valid, halted, stall_cycles
  );
endinterface

// File: rtl/io_stall_ctrl.sv
// Stall sequencer for the IN, OUT and STOP instructions.
//   IN   : hold the PC until an input word arrives, then write it back.
//   OUT  : latch the value onto the display and hold the PC OUT_HOLD_CYC cycles.
//   STOP : park the core until a resume pulse.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : io_stall_ctrl_if slave (decoder strobes, I/O words, pc_en,
//          rd_we/rd_data, out_reg/out_valid, halted, stall_cycles)
module io_stall_ctrl #(
  parameter int DATA_W       = 32,
  parameter int OUT_HOLD_CYC = 4,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  io_stall_ctrl_if.slave bus
);

  localparam int HOLD_W = (OUT_HOLD_CYC > 1) ? $clog2(OUT_HOLD_CYC) : 1;

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_WAIT_IN  = 3'd1,
    S_IN_WB    = 3'd2,
    S_OUT_HOLD = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [HOLD_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_out_reg;
  logic              r_in_ack;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_stall;

  logic w_pc_en;
  logic w_rd_we;
  logic w_halted;
  logic w_capture_in;
  logic w_load_out;

  always_comb begin
    w_next       = r_state;
    w_pc_en      = 1'b1;
    w_rd_we      = 1'b0;
    w_halted     = 1'b0;
    w_capture_in = 1'b0;
    w_load_out   = 1'b0;
    case (r_state)
      S_RUN: begin
        w_pc_en = ~(bus.inop | bus.outop | bus.sleep);
        if (bus.sleep) begin
          w_next = S_HALT;
        end else if (bus.inop) begin
          w_next = S_WAIT_IN;
        end else if (bus.outop) begin
          w_load_out = 1'b1;
          w_next     = S_OUT_HOLD;
        end
      end
      S_WAIT_IN: begin
        w_pc_en = 1'b0;
        if (bus.in_valid) begin
          w_capture_in = 1'b1;
          w_next       = S_IN_WB;
        end
      end
      S_IN_WB: begin
        w_rd_we = 1'b1;
        w_next  = S_RUN;
      end
      S_OUT_HOLD: begin
        // The RUN detect cycle is the first stalled cycle, so the counter
        // starts at OUT_HOLD_CYC-1 and the PC is released when it reaches 0.
        w_pc_en = (r_cnt == '0);
        if (r_cnt == '0) w_next = S_RUN;
      end
      S_HALT: begin
        w_halted = 1'b1;
        w_pc_en  = bus.resume;
        if (bus.resume) w_next = S_RUN;
      end
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_cnt       <= '0;
      r_rd_data   <= '0;
      r_out_reg   <= '0;
      r_in_ack    <= 1'b0;
      r_out_valid <= 1'b0;
      r_stall     <= '0;
    end else begin
      r_state     <= w_next;
      r_in_ack    <= w_capture_in;
      r_out_valid <= w_load_out;
      if (w_capture_in) r_rd_data <= bus.in_data;
      if (w_load_out) begin
        r_out_reg <= bus.out_data;
        r_cnt     <= HOLD_W'(OUT_HOLD_CYC - 1);
      end else if (r_state == S_OUT_HOLD && r_cnt != '0) begin
        r_cnt <= r_cnt - HOLD_W'(1);
      end
      if (!w_pc_en && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.rd_we        = w_rd_we;
  assign bus.halted       = w_halted;
  assign bus.in_ack       = r_in_ack;
  assign bus.rd_data      = r_rd_data;
  assign bus.out_reg      = r_out_reg;
  assign bus.out_valid    = r_out_valid;
  assign bus.stall_cycles = r_stall;

endmodule

// File: tb/tb_io_stall_ctrl.sv
module tb_io_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_stall_ctrl_if #(.DATA_W(32), .CNT_W(4)) if0 ();
  io_stall_ctrl_if #(.DATA_W(32), .CNT_W(4)) if1 ();

  io_stall_ctrl #(.DATA_W(32), .OUT_HOLD_CYC(4), .CNT_W(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  io_stall_ctrl #(.DATA_W(32), .OUT_HOLD_CYC(1), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  typedef struct {
    string       name;
    logic        rst, inop, outop, sleep, in_valid, resume;
    logic [31:0] in_data, out_data;
    logic        pc_en, in_ack, rd_we, out_valid, halted;
    logic [31:0] rd_data, out_reg;
    logic [3:0]  stall;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(string name, logic r, logic io, logic oo, logic sl,
                              logic iv, logic [31:0] id, logic rs, logic [31:0] od,
                              logic pe, logic ia, logic we, logic [31:0] rd,
                              logic [31:0] orr, logic ov, logic h, logic [3:0] st);
    vec_t v;
    v.name = name; v.rst = r; v.inop = io; v.outop = oo; v.sleep = sl;
    v.in_valid = iv; v.in_data = id; v.resume = rs; v.out_data = od;
    v.pc_en = pe; v.in_ack = ia; v.rd_we = we; v.rd_data = rd;
    v.out_reg = orr; v.out_valid = ov; v.halted = h; v.stall = st;
    return v;
  endfunction

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] pack0();
    return {if0.pc_en, if0.in_ack, if0.rd_we, if0.out_valid, if0.halted,
            if0.rd_data, if0.out_reg, if0.stall_cycles};
  endfunction

  function automatic logic [79:0] pack_v(vec_t v);
    return {v.pc_en, v.in_ack, v.rd_we, v.out_valid, v.halted,
            v.rd_data, v.out_reg, v.stall};
  endfunction

  // Drive dut0 inputs on the falling edge; checks follow #1 later.
  task automatic drive(logic r, logic io, logic oo, logic sl, logic iv,
                       logic [31:0] id, logic rs, logic [31:0] od);
    @(negedge clk);
    rst = r; if0.inop = io; if0.outop = oo; if0.sleep = sl;
    if0.in_valid = iv; if0.in_data = id; if0.resume = rs; if0.out_data = od;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    idle();
  endtask

  initial begin
    if0.inop = 0; if0.outop = 0; if0.sleep = 0; if0.in_valid = 0;
    if0.in_data = '0; if0.resume = 0; if0.out_data = '0;
    if1.inop = 0; if1.outop = 0; if1.sleep = 0; if1.in_valid = 0;
    if1.in_data = '0; if1.resume = 0; if1.out_data = '0;

    //                    name        r io oo sl iv in_data     rs out_data     pe ia we rd_data      out_reg      ov h  st
    tbl.push_back(mk("reset",        0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      1, 0, 0, 32'h0,      32'h0,      0, 0, 4'd0));
    tbl.push_back(mk("in_detect",    0, 1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 32'h0,      32'h0,      0, 0, 4'd0));
    tbl.push_back(mk("in_wait1",     0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 32'h0,      32'h0,      0, 0, 4'd1));
    tbl.push_back(mk("in_wait2",     0, 0, 1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 32'h0,      32'h0,      0, 0, 4'd2));
    tbl.push_back(mk("in_wait3",     0, 0, 0, 1, 0, 32'h0,      1, 32'h0,      0, 0, 0, 32'h0,      32'h0,      0, 0, 4'd3));
    tbl.push_back(mk("in_wait4",     0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 32'h0,      32'h0,      0, 0, 4'd4));
    tbl.push_back(mk("in_valid",     0, 0, 0, 0, 1, 32'hA5,     0, 32'h0,      0, 0, 0, 32'h0,      32'h0,      0, 0, 4'd5));
    tbl.push_back(mk("in_wb",        0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      1, 1, 1, 32'hA5,     32'h0,      0, 0, 4'd6));
    tbl.push_back(mk("in_done",      0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      1, 0, 0, 32'hA5,     32'h0,      0, 0, 4'd6));
    tbl.push_back(mk("stray_valid",  0, 0, 0, 0, 1, 32'hFF,     0, 32'h0,      1, 0, 0, 32'hA5,     32'h0,      0, 0, 4'd6));
    tbl.push_back(mk("stray_after",  0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      1, 0, 0, 32'hA5,     32'h0,      0, 0, 4'd6));
    tbl.push_back(mk("rst_cycle",    1, 0, 0, 0, 0, 32'h0,      0, 32'h0,      1, 0, 0, 32'hA5,     32'h0,      0, 0, 4'd6));
    tbl.push_back(mk("post_rst",     0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      1, 0, 0, 32'h0,      32'h0,      0, 0, 4'd0));
    tbl.push_back(mk("out_detect",   0, 0, 1, 0, 0, 32'h0,      0, 32'h1234,   0, 0, 0, 32'h0,      32'h0,      0, 0, 4'd0));
    tbl.push_back(mk("out_hold3",    0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 32'h0,      32'h1234,   1, 0, 4'd1));
    tbl.push_back(mk("out_hold2",    0, 1, 0, 0, 1, 32'h9,      0, 32'h0,      0, 0, 0, 32'h0,      32'h1234,   0, 0, 4'd2));
    tbl.push_back(mk("out_hold1",    0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 32'h0,      32'h1234,   0, 0, 4'd3));
    tbl.push_back(mk("out_release",  0, 0, 0, 1, 0, 32'h0,      0, 32'h0,      1, 0, 0, 32'h0,      32'h1234,   0, 0, 4'd4));
    tbl.push_back(mk("out_done",     0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      1, 0, 0, 32'h0,      32'h1234,   0, 0, 4'd4));
    tbl.push_back(mk("all_strobes",  0, 1, 1, 1, 0, 32'h0,      0, 32'hDEAD,   0, 0, 0, 32'h0,      32'h1234,   0, 0, 4'd4));
    tbl.push_back(mk("conf_halt",    0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 32'h0,      32'h1234,   0, 1, 4'd5));
    tbl.push_back(mk("conf_resume",  0, 0, 0, 0, 0, 32'h0,      1, 32'h0,      1, 0, 0, 32'h0,      32'h1234,   0, 1, 4'd6));
    tbl.push_back(mk("conf_run",     0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      1, 0, 0, 32'h0,      32'h1234,   0, 0, 4'd6));
    tbl.push_back(mk("stray_resume", 0, 0, 0, 0, 0, 32'h0,      1, 32'h0,      1, 0, 0, 32'h0,      32'h1234,   0, 0, 4'd6));
    tbl.push_back(mk("stray_res2",   0, 0, 0, 0, 0, 32'h0,      0, 32'h0,      1, 0, 0, 32'h0,      32'h1234,   0, 0, 4'd6));

    // Two reset edges before the table starts.
    @(negedge clk); @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].inop, tbl[i].outop, tbl[i].sleep,
            tbl[i].in_valid, tbl[i].in_data, tbl[i].resume, tbl[i].out_data);
      chk(tbl[i].name, pack0(), pack_v(tbl[i]));
    end

    // STOP: 10 stalled cycles (detect + 9 in HALT), then resume commits.
    do_reset();
    drive(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    chk("stop_detect", {if0.pc_en, if0.halted}, 2'b00);
    for (int unsigned k = 1; k < 10; k++) begin
      idle();
      chk("stop_halted", {if0.pc_en, if0.halted}, 2'b01);
    end
    drive(0, 0, 0, 0, 0, 32'h0, 1, 32'h0);
    chk("stop_resume", {if0.pc_en, if0.halted, if0.stall_cycles}, {2'b11, 4'd10});
    idle();
    chk("stop_after", {if0.pc_en, if0.halted, if0.stall_cycles}, {2'b10, 4'd10});

    // Reset while waiting for input: pending capture is aborted.
    do_reset();
    drive(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(); idle(); idle();
    drive(1, 0, 0, 0, 1, 32'h77, 0, 32'h0);
    chk("rstwait_during", {31'h0, if0.pc_en}, 32'h0);
    idle();
    chk("rstwait_after", {if0.pc_en, if0.rd_we, if0.in_ack, if0.rd_data},
        {3'b100, 32'h0});
    idle();
    chk("rstwait_later", {if0.pc_en, if0.rd_we, if0.in_ack, if0.rd_data},
        {3'b100, 32'h0});

    // Reset while holding an OUT: display latch cleared, PC released.
    drive(0, 0, 1, 0, 0, 32'h0, 0, 32'h55);
    idle();
    chk("rstout_latched", if0.out_reg, 32'h55);
    drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    idle();
    chk("rstout_after", {if0.pc_en, if0.out_valid, if0.out_reg}, {2'b10, 32'h0});
    idle();
    chk("rstout_later", {if0.pc_en, if0.out_reg}, {1'b1, 32'h0});

    // Saturating stall counter: 21 stalled cycles with CNT_W=4.
    do_reset();
    drive(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    for (int unsigned k = 0; k < 19; k++) idle();
    drive(0, 0, 0, 0, 1, 32'h3C, 0, 32'h0);
    chk("sat_wait", if0.stall_cycles, 4'd15);
    idle();
    chk("sat_wb", {if0.rd_we, if0.rd_data, if0.stall_cycles}, {1'b1, 32'h3C, 4'd15});

    // OUT_HOLD_CYC=1: exactly one stalled cycle.
    do_reset();
    @(negedge clk); if1.outop = 1'b1; if1.out_data = 32'hC0DE; #1;
    chk("hold1_detect", {if1.pc_en, if1.stall_cycles}, {1'b0, 4'd0});
    @(negedge clk); if1.outop = 1'b0; if1.out_data = 32'h0; #1;
    chk("hold1_release", {if1.pc_en, if1.out_valid, if1.out_reg, if1.stall_cycles},
        {2'b11, 32'hC0DE, 4'd1});
    @(negedge clk); #1;
    chk("hold1_run", {if1.pc_en, if1.out_valid, if1.stall_cycles}, {2'b10, 4'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
